// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator and incremental frame-buffer address sequencer.
// Build macro VGA_TEST_PATTERN_EN adds the tp_en input and an 8-bar colour test pattern.
module vga_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_DISP   = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_DISP   = 480,
  parameter int V_FRONT  = 10,
  parameter int CNT_W    = 11,
  parameter int PIX_W    = 12,
  parameter int ADDR_W   = 19,
  parameter int REQ_LEAD = 1,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter logic [PIX_W-1:0] OVL_COLOR = 12'hFFF
) (
  input  logic              vga_clk,
  input  logic              sys_rst,
  input  logic              scale_2x,
  input  logic              overlay_en,
  input  logic [CNT_W-1:0]  ovl_x0,
  input  logic [CNT_W-1:0]  ovl_x1,
  input  logic [CNT_W-1:0]  ovl_y0,
  input  logic [CNT_W-1:0]  ovl_y1,
  input  logic [PIX_W-1:0]  pixel_data,
`ifdef VGA_TEST_PATTERN_EN
  input  logic              tp_en,
`endif
  output logic              data_req,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_de,
  output logic [PIX_W-1:0]  vga_rgb,
  output logic              frame_start,
  output logic              line_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int H_START = H_SYNC + H_BACK;
  localparam int V_START = V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0]  H_LAST_C    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0]  V_LAST_C    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0]  H_SYNC_C    = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0]  V_SYNC_C    = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0]  H_START_C   = CNT_W'(H_START);
  localparam logic [CNT_W-1:0]  H_END_C     = CNT_W'(H_START + H_DISP);
  localparam logic [CNT_W-1:0]  V_START_C   = CNT_W'(V_START);
  localparam logic [CNT_W-1:0]  V_END_C     = CNT_W'(V_START + V_DISP);
  localparam logic [CNT_W-1:0]  REQ_START_C = CNT_W'(H_START - REQ_LEAD);
  localparam logic [CNT_W-1:0]  REQ_END_C   = CNT_W'(H_START - REQ_LEAD + H_DISP);
  localparam logic [CNT_W-1:0]  REQ_LAST_C  = CNT_W'(H_START - REQ_LEAD + H_DISP - 1);
  localparam logic [ADDR_W-1:0] HALF_C      = ADDR_W'(H_DISP / 2);

  logic [CNT_W-1:0] h_cnt, v_cnt;

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST_C) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST_C) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  logic at_origin, v_act, h_act, h_req, req_now, req_last, disp_odd;

  assign at_origin = (h_cnt == '0) && (v_cnt == '0);
  assign v_act     = (v_cnt >= V_START_C) && (v_cnt < V_END_C);
  assign h_act     = (h_cnt >= H_START_C) && (h_cnt < H_END_C);
  assign h_req     = (h_cnt >= REQ_START_C) && (h_cnt < REQ_END_C);
  assign req_now   = h_req && v_act;
  assign req_last  = (h_cnt == REQ_LAST_C);
  assign disp_odd  = v_cnt[0] ^ V_START_C[0];

  // Frame-start shadows: mid-frame input changes wait for the next frame
  logic             scale_s, ovl_en_s;
  logic [CNT_W-1:0] x0_s, x1_s, y0_s, y1_s;

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      scale_s  <= 1'b0;
      ovl_en_s <= 1'b0;
      x0_s     <= '0;
      x1_s     <= '0;
      y0_s     <= '0;
      y1_s     <= '0;
    end else if (at_origin) begin
      scale_s  <= scale_2x;
      ovl_en_s <= overlay_en;
      x0_s     <= ovl_x0;
      x1_s     <= ovl_x1;
      y0_s     <= ovl_y0;
      y1_s     <= ovl_y1;
    end
  end

  logic [CNT_W-1:0] px_q, py_q;

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      vga_hs      <= ~HS_POL;
      vga_vs      <= ~VS_POL;
      vga_de      <= 1'b0;
      data_req    <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      px_q        <= '0;
      py_q        <= '0;
    end else begin
      vga_hs      <= (h_cnt < H_SYNC_C) ? HS_POL : ~HS_POL;
      vga_vs      <= (v_cnt < V_SYNC_C) ? VS_POL : ~VS_POL;
      vga_de      <= h_act && v_act;
      data_req    <= req_now;
      frame_start <= at_origin;
      line_start  <= (h_cnt == '0);
      px_q        <= h_cnt - H_START_C;
      py_q        <= v_cnt - V_START_C;
    end
  end

  // In 2x mode each source pixel is requested twice and each source line is walked twice
  logic [ADDR_W-1:0] addr_cnt, line_base;
  logic              pair;

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pixel_addr <= '0;
      addr_cnt   <= '0;
      line_base  <= '0;
      pair       <= 1'b0;
    end else if (at_origin) begin
      pixel_addr <= '0;
      addr_cnt   <= '0;
      line_base  <= '0;
      pair       <= 1'b0;
    end else if (req_now) begin
      pixel_addr <= addr_cnt;
      if (!scale_s) begin
        addr_cnt <= addr_cnt + 1'b1;
      end else if (req_last) begin
        pair <= 1'b0;
        if (disp_odd) begin
          line_base <= line_base + HALF_C;
          addr_cnt  <= line_base + HALF_C;
        end else begin
          addr_cnt  <= line_base;
        end
      end else begin
        pair <= ~pair;
        if (pair) addr_cnt <= addr_cnt + 1'b1;
      end
    end
  end

  logic x_in, y_in, x_edge, y_edge, ovl_hit;

  assign x_in    = (px_q >= x0_s) && (px_q <= x1_s);
  assign y_in    = (py_q >= y0_s) && (py_q <= y1_s);
  assign x_edge  = (px_q == x0_s) || (px_q == x1_s);
  assign y_edge  = (py_q == y0_s) || (py_q == y1_s);
  assign ovl_hit = ovl_en_s && ((y_edge && x_in) || (x_edge && y_in));

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_DISP / 8;
  localparam int CW    = PIX_W / 3;
  localparam logic [CNT_W-1:0] BAR_LAST_C = CNT_W'(BAR_W - 1);

  logic             tp_s;
  logic [CNT_W-1:0] bar_col;
  logic [2:0]       bar_idx;
  logic [PIX_W-1:0] bar_rgb;

  // Bar position tracked incrementally alongside vga_de, avoiding a divide by BAR_W
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tp_s    <= 1'b0;
      bar_col <= '0;
      bar_idx <= '0;
    end else begin
      if (at_origin) tp_s <= tp_en;
      if (h_cnt == H_START_C) begin
        bar_col <= '0;
        bar_idx <= '0;
      end else if (vga_de) begin
        if (bar_col == BAR_LAST_C) begin
          bar_col <= '0;
          bar_idx <= bar_idx + 1'b1;
        end else begin
          bar_col <= bar_col + 1'b1;
        end
      end
    end
  end

  assign bar_rgb = PIX_W'({{CW{bar_idx[2]}}, {CW{bar_idx[1]}}, {CW{bar_idx[0]}}});
`endif

  always_comb begin
    vga_rgb = '0;
    if (vga_de) begin
      if (ovl_hit)
        vga_rgb = OVL_COLOR;
`ifdef VGA_TEST_PATTERN_EN
      else if (tp_s)
        vga_rgb = bar_rgb;
`endif
      else
        vga_rgb = pixel_data;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a reduced raster, with a scoreboard of fetched pixels.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int HS = 8, HB = 6, HD = 32, HF = 4;
  localparam int VS = 2, VB = 3, VD = 12, VF = 2;
  localparam int HT = HS + HB + HD + HF;
  localparam int VT = VS + VB + VD + VF;
  localparam int FRAME = HT * VT;
  localparam int HSTART = HS + HB;
  localparam int VSTART = VS + VB;
  localparam int LEAD = 3;
  localparam int CW = 11, PW = 12, AW = 19;
  localparam int MAX_CYC = 20000;

  logic          vga_clk = 1'b0, sys_rst = 1'b0, scale_2x = 1'b0, overlay_en = 1'b0;
  logic [CW-1:0] ovl_x0 = 11'd5, ovl_x1 = 11'd20, ovl_y0 = 11'd3, ovl_y1 = 11'd8;
  logic [PW-1:0] pixel_data = '0;
`ifdef VGA_TEST_PATTERN_EN
  logic          tp_en = 1'b0;
`endif
  logic          data_req, vga_hs, vga_vs, vga_de, frame_start, line_start;
  logic [AW-1:0] pixel_addr;
  logic [PW-1:0] vga_rgb;

  vga_timing_gen #(
    .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
    .CNT_W(CW), .PIX_W(PW), .ADDR_W(AW), .REQ_LEAD(LEAD),
    .HS_POL(1'b0), .VS_POL(1'b0), .OVL_COLOR(12'hFFF)
  ) dut (
    .vga_clk(vga_clk), .sys_rst(sys_rst), .scale_2x(scale_2x), .overlay_en(overlay_en),
    .ovl_x0(ovl_x0), .ovl_x1(ovl_x1), .ovl_y0(ovl_y0), .ovl_y1(ovl_y1),
    .pixel_data(pixel_data),
`ifdef VGA_TEST_PATTERN_EN
    .tp_en(tp_en),
`endif
    .data_req(data_req), .pixel_addr(pixel_addr), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_de(vga_de), .vga_rgb(vga_rgb), .frame_start(frame_start), .line_start(line_start)
  );

  always #5 vga_clk = ~vga_clk;

  int n_chk = 0, n_fail = 0;
  int n, p, h, v, fi;
  bit done;

  logic e_hs, e_vs, e_de, e_req, e_fs, e_ls;
  int   e_addr;
  logic [PW-1:0] e_rgb;
  logic [PW-1:0] sb[$];
  bit   sh_scale, sh_en;
  int   sh_x0, sh_x1, sh_y0, sh_y1;
  logic [AW-1:0] pa [0:LEAD];

  bit   tal_ok, prev_scale, prev_req, prev_de;
  int   cnt_hs, cnt_vs, cnt_de, cnt_req, last_req_addr, last_fs, req_rise_n;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  function automatic logic [PW-1:0] fb_word(input logic [AW-1:0] a);
    return PW'(a * 5) ^ 12'hA5C;
  endfunction

  task automatic reset_model();
    n = 0;
    {e_hs, e_vs, e_de, e_req, e_fs, e_ls} = 6'b110000;
    e_addr = 0; e_rgb = '0;
    sh_scale = 0; sh_en = 0; sh_x0 = 0; sh_x1 = 0; sh_y0 = 0; sh_y1 = 0;
    sb.delete();
    tal_ok = 0; prev_req = 0; prev_de = 0; last_fs = 0; req_rise_n = 0;
    cnt_hs = 0; cnt_vs = 0; cnt_de = 0; cnt_req = 0; last_req_addr = 0;
  endtask

  // Outputs after clock n describe raster position n-1 of the current frame
  task automatic step_model();
    int x, y;
    bit vin, hit;
    logic [PW-1:0] d;
    p = (n - 1) % FRAME;
    h = p % HT;
    v = p / HT;
    if (p == 0) begin
      fi++;
      sh_scale = scale_2x; sh_en = overlay_en;
      sh_x0 = int'(ovl_x0); sh_x1 = int'(ovl_x1); sh_y0 = int'(ovl_y0); sh_y1 = int'(ovl_y1);
      e_addr = 0;
    end
    vin   = (v >= VSTART) && (v < VSTART + VD);
    e_hs  = !(h < HS);
    e_vs  = !(v < VS);
    e_de  = vin && (h >= HSTART) && (h < HSTART + HD);
    e_req = vin && (h >= HSTART - LEAD) && (h < HSTART - LEAD + HD);
    e_fs  = (p == 0);
    e_ls  = (h == 0);
    if (e_req) begin
      x = h - (HSTART - LEAD);
      y = v - VSTART;
      e_addr = sh_scale ? (y / 2) * (HD / 2) + x / 2 : y * HD + x;
      sb.push_back(fb_word(AW'(e_addr)));
    end
    e_rgb = '0;
    if (e_de) begin
      x = h - HSTART;
      y = v - VSTART;
      hit = sh_en && (((y == sh_y0 || y == sh_y1) && x >= sh_x0 && x <= sh_x1) ||
                      ((x == sh_x0 || x == sh_x1) && y >= sh_y0 && y <= sh_y1));
      d = (sb.size() != 0) ? sb.pop_front() : 'x;
      e_rgb = hit ? 12'hFFF : d;
    end
  endtask

  task automatic chk_outputs();
    chk("ctl", {26'd0, vga_hs, vga_vs, vga_de, data_req, frame_start, line_start},
               {26'd0, e_hs, e_vs, e_de, e_req, e_fs, e_ls});
    chk("addr", 32'(pixel_addr), 32'(e_addr));
    chk("rgb", 32'(vga_rgb), 32'(e_rgb));
  endtask

  task automatic tally();
    if (p == 0) begin
      if (tal_ok) begin
        chk("hs_low_per_frame", 32'(cnt_hs), 32'(HS * VT));
        chk("vs_low_per_frame", 32'(cnt_vs), 32'(VS * HT));
        chk("de_per_frame", 32'(cnt_de), 32'(HD * VD));
        chk("req_per_frame", 32'(cnt_req), 32'(HD * VD));
        chk("last_addr", 32'(last_req_addr), prev_scale ? 32'((HD / 2) * (VD / 2) - 1) : 32'(HD * VD - 1));
      end
      tal_ok = 1; prev_scale = sh_scale;
      cnt_hs = 0; cnt_vs = 0; cnt_de = 0; cnt_req = 0;
    end
    cnt_hs  += int'(!vga_hs);
    cnt_vs  += int'(!vga_vs);
    cnt_de  += int'(vga_de);
    cnt_req += int'(data_req);
    if (data_req) last_req_addr = int'(pixel_addr);
    if (data_req && !prev_req) req_rise_n = n;
    if (vga_de && !prev_de) chk("req_lead", 32'(n - req_rise_n), 32'(LEAD));
    prev_req = data_req; prev_de = vga_de;
    if (frame_start) begin
      if (last_fs > 0) chk("fs_period", 32'(n - last_fs), 32'(FRAME));
      last_fs = n;
    end
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    #1;
    reset_model();
    chk_outputs();
    repeat (5) begin
      @(posedge vga_clk);
      #1;
      chk_outputs();
    end
    @(negedge vga_clk);
    sys_rst = 1'b0;
    #1;
    chk_outputs();
  endtask

  task automatic schedule();
    if (fi == 1 && p == FRAME - 5) overlay_en = 1'b1;
    if (fi == 2 && p == HT * 8) ovl_x0 = 11'd9;
    if (fi == 2 && p == FRAME - 5) begin scale_2x = 1'b1; ovl_y1 = 11'd15; end
    if (fi == 3 && p == FRAME - 5) ovl_x1 = 11'd40;
    if (fi == 4 && p == FRAME - 5) begin scale_2x = 1'b0; overlay_en = 1'b0; end
    if (fi == 5 && p == 8 * HT + 30) do_reset();
    if (fi == 7 && p == 10) done = 1;
  endtask

  initial begin
    int total;
    fi = 0; done = 0; total = 0; p = 0;
    for (int k = 0; k <= LEAD; k++) pa[k] = '0;
    reset_model();
    #1 sys_rst = 1'b1;
    repeat (3) @(posedge vga_clk);
    #1 chk_outputs();
    @(negedge vga_clk);
    sys_rst = 1'b0;
    #1 chk_outputs();
    while (!done) begin
      @(posedge vga_clk);
      #1;
      for (int k = LEAD; k > 0; k--) pa[k] = pa[k-1];
      pa[0] = pixel_addr;
      pixel_data = fb_word(pa[LEAD]);
      #1;
      n++; total++;
      step_model();
      chk_outputs();
      tally();
      schedule();
      if (total > MAX_CYC) begin
        chk("cycle_budget", 32'(total), 32'(MAX_CYC));
        done = 1;
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA/SVGA raster timing generator and frame-buffer address sequencer; next generation of the camera display driver.
- Sits between the pixel-clock domain frame buffer (BRAM/SDRAM read port) and the VGA connector.
- Generalises timing, pixel width, sync polarity and fetch lead, and adds:
  - 2x pixel-doubling mode;
  - frame-latched rectangular overlay box;
  - frame/line strobes.
- Address is generated incrementally; no multiplier.

Parameters:
H_SYNC, 96, horizontal sync width (clocks)
H_BACK, 48, horizontal back porch
H_DISP, 640, horizontal active pixels (must be even)
H_FRONT, 16, horizontal front porch
V_SYNC, 2, vertical sync lines
V_BACK, 33, vertical back porch
V_DISP, 480, vertical active lines (must be even)
V_FRONT, 10, vertical front porch
CNT_W, 11, width of h/v counters and overlay coordinates
PIX_W, 12, pixel width (RGB444 default)
ADDR_W, 19, frame-buffer address width
REQ_LEAD, 1, clocks data_req precedes vga_de (legal 1..4)
HS_POL, 0, active level of vga_hs
VS_POL, 0, active level of vga_vs
OVL_COLOR, 12'hFFF, overlay pixel value

Ports:
vga_clk  in  1  pixel clock; the only clock
sys_rst  in  1  asynchronous, active-high reset
scale_2x  in  1  1 = 2x pixel-doubled fetch; sampled at frame start
overlay_en  in  1  overlay box enable; sampled at frame start
ovl_x0  in  CNT_W  box left column (active-area coordinates)
ovl_x1  in  CNT_W  box right column
ovl_y0  in  CNT_W  box top line
ovl_y1  in  CNT_W  box bottom line
pixel_data  in  PIX_W  frame-buffer read data, valid REQ_LEAD clocks after its address
data_req  out  1  fetch request; pixel_addr valid this cycle
pixel_addr  out  ADDR_W  frame-buffer read address
vga_hs  out  1  horizontal sync
vga_vs  out  1  vertical sync
vga_de  out  1  active-video enable
vga_rgb  out  PIX_W  pixel output
frame_start  out  1  one-clock pulse at h=0, v=0
line_start  out  1  one-clock pulse at h=0 of every line

Behaviour:
Reset and counters
- Asynchronous reset: all registers 0; vga_hs = !HS_POL, vga_vs = !VS_POL; all other outputs 0.
- H_TOTAL = sum of the H_* parameters; V_TOTAL = sum of the V_* parameters.
- h_cnt counts 0..H_TOTAL-1 and wraps.
- v_cnt increments when h_cnt = H_TOTAL-1 and wraps at V_TOTAL-1.

Syncs and enables
- vga_hs is active (= HS_POL) for h_cnt < H_SYNC.
- vga_vs is active (= VS_POL) for v_cnt < V_SYNC.
- vga_de = 1 for h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP) and v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP).
- data_req is the same window shifted REQ_LEAD clocks earlier in h, same v window. Exactly H_DISP requests per active line.
- frame_start and line_start are registered from the counters, with no further latency.

Shadow registers
- At h=0, v=0, scale_2x, overlay_en and ovl_* are copied to shadow registers.
- Mid-frame input changes are ignored until the next frame.
- Reset clears the shadows.

Address sequencer, scale 0
- pixel_addr is updated with the data_req cycle.
- Addresses run 0..H_DISP*V_DISP-1 across the frame, +1 per request.

Address sequencer, scale 1
- Source image is H_DISP/2 x V_DISP/2.
- Address advances on every second request within a line.
- Even display line: ends by rewinding to line_base.
- Odd display line: ends with line_base += H_DISP/2.
- Last address = (H_DISP/2)*(V_DISP/2)-1.

Address boundaries
- pixel_addr and line_base reset to 0 at frame_start.
- pixel_addr holds its value when data_req = 0; no 0-forcing, to save BRAM toggling.

Pixel output
- vga_rgb is combinational:
  - 0 when vga_de = 0;
  - else OVL_COLOR when the overlay hits;
  - else pixel_data.
- Overlay hit: shadow overlay_en = 1, with active x in [x0,x1] and y = y0 or y = y1, or y in [y0,y1] and x = x0 or x = x1 (outline only).
- x0 > x1 or y0 > y1 gives no hit on that axis pair.
- Coordinates ≥ H_DISP/V_DISP never hit.

Reset mid-frame
- Outputs return to reset values immediately.
- The first frame after release starts at h=0, v=0 with frame_start on the first clock.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- When defined:
  - adds input tp_en (1 bit), sampled at frame start;
  - when the shadow is 1, pixel_data is ignored and vga_rgb shows 8 vertical colour bars, each H_DISP/8 wide;
  - bar k = {R,G,B} each all-ones/zero from bits k[2],k[1],k[0], replicated to PIX_W/3 bits each;
  - the overlay is still applied on top;
  - data_req still toggles.
- When undefined: no tp_en port and no bar logic.

Test Plan:
- Default params, release reset, run 2 frames:
  - vga_hs low 96 clocks per 800;
  - vga_vs low 2 lines per 525;
  - 640x480 vga_de clocks per frame;
  - frame_start period 420000.
- REQ_LEAD=3: data_req rises exactly 3 clocks before vga_de on every active line.
- pixel_addr:
  - scale_2x=0: first active addr 0, line-1 start 640, last addr 307199;
  - scale_2x=1: lines 0 and 1 both 0..319, each value twice; line 2 starts 320; last addr 76799.
- Overlay x0=261, x1=474, y0=160, y1=320, pixel_data=12'h123:
  - 12'hFFF on the outline only;
  - 12'h123 inside;
  - changing ovl_x0 mid-frame takes effect only after the next frame_start.
- Assert sys_rst at h=300, v=200 for 5 clocks:
  - outputs at reset values immediately (asynchronously);
  - after release, frame_start on the first clock and pixel_addr restarts at 0.
- VGA_TEST_PATTERN_EN, tp_en=1: active column 0 = 12'h000, column 80 = 12'h00F, column 560 = 12'hFFF.
